hazard_sched: RTL and testbench

Pipeline hazard scheduler for the five-stage core: sits beside the ID stage and decides, each cycle, whether the instruction in IF/ID may advance or must stall, and which source feeds the ID-stage branch comparator (the `forwardSignal` of ID). It keeps its own three-entry scoreboard of destination registers in flight (EX, MEM, WB), so it needs no taps into the later pipeline registers.

---
 rtl/hazard_sched.sv | 145 ++++++++++++++
 tb/tb_hazard_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// hazard_sched: ID-stage hazard scheduler for the five-stage core.
//
// Decides each cycle whether the IF/ID instruction may advance or must stall.
// It also selects the source for each operand of the ID-stage branch comparator.
// A private three-entry scoreboard (EX, MEM, WB) tracks destination registers
// in flight, so no taps into the later pipeline registers are needed.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-low reset
//   id_*             decoded fields of the instruction currently in IF/ID
//   flush            taken branch/jump; the IF/ID occupant is squashed
//   stall            hold PC and IF/ID, insert a bubble into EX
//   pc_write         ~stall
//   if_id_write      ~stall
//   forward_signal   [3:2] rs, [1:0] rt: 00 regfile, 01 EX/MEM ALU result, 10 WB value
//   stall_cause      00 none, 01 load-use, 10 branch-on-ALU, 11 branch-on-load
//   stall_cnt        saturating count of stall cycles since reset
module hazard_sched #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_reg_write,
    input  logic             id_load,
    input  logic [REG_W-1:0] id_dst,
    input  logic             flush,
    output logic             stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic [3:0]       forward_signal,
    output logic [1:0]       stall_cause,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             load;
        logic [REG_W-1:0] dst;
    } sb_entry_t;

    // WB never needs the load flag: the value is final by then.
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic [REG_W-1:0] dst;
    } wb_entry_t;

    sb_entry_t        ex_q, ex_d, mem_q;
    wb_entry_t        wb_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic active, load_use, br_alu, br_load, fwd_en;

    // Register 0 is hard-wired, so it can never create a dependency.
    function automatic logic src_match(input logic             used,
                                       input logic [REG_W-1:0] idx,
                                       input logic             valid,
                                       input logic             reg_write,
                                       input logic [REG_W-1:0] dst);
        return used && (idx != '0) && valid && reg_write && (dst == idx);
    endfunction

    always_comb begin
        rs_ex  = src_match(id_use_rs, id_rs, ex_q.valid, ex_q.reg_write, ex_q.dst);
        rt_ex  = src_match(id_use_rt, id_rt, ex_q.valid, ex_q.reg_write, ex_q.dst);
        rs_mem = src_match(id_use_rs, id_rs, mem_q.valid, mem_q.reg_write, mem_q.dst);
        rt_mem = src_match(id_use_rt, id_rt, mem_q.valid, mem_q.reg_write, mem_q.dst);
        rs_wb  = src_match(id_use_rs, id_rs, wb_q.valid, wb_q.reg_write, wb_q.dst);
        rt_wb  = src_match(id_use_rt, id_rt, wb_q.valid, wb_q.reg_write, wb_q.dst);

        // A squashed or empty slot never stalls.
        active   = id_valid & ~flush;
        load_use = active & (rs_ex | rt_ex) & ex_q.load;
        br_alu   = active & id_branch & (rs_ex | rt_ex) & ~ex_q.load;
        br_load  = active & id_branch & (rs_mem | rt_mem) & mem_q.load;

        stall = load_use | br_alu | br_load;

        if (br_load) begin
            stall_cause = 2'b11;
        end else if (load_use) begin
            stall_cause = 2'b01;
        end else if (br_alu) begin
            stall_cause = 2'b10;
        end else begin
            stall_cause = 2'b00;
        end

        // Only the ID comparator is served here; EX forwarding lives elsewhere.
        fwd_en         = id_branch & ~stall;
        forward_signal = 4'b0000;
        if (fwd_en) begin
            if (rs_mem && !mem_q.load) begin
                forward_signal[3:2] = 2'b01;
            end else if (rs_wb) begin
                forward_signal[3:2] = 2'b10;
            end
            if (rt_mem && !mem_q.load) begin
                forward_signal[1:0] = 2'b01;
            end else if (rt_wb) begin
                forward_signal[1:0] = 2'b10;
            end
        end

        pc_write    = ~stall;
        if_id_write = ~stall;

        if (stall | flush | ~id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = {id_valid, id_reg_write, id_load, id_dst};
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= {mem_q.valid, mem_q.reg_write, mem_q.dst};
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
module tb_hazard_sched;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_branch;
    logic             id_reg_write;
    logic             id_load;
    logic [REG_W-1:0] id_dst;
    logic             flush;
    logic             stall;
    logic             pc_write;
    logic             if_id_write;
    logic [3:0]       forward_signal;
    logic [1:0]       stall_cause;
    logic [CNT_W-1:0] stall_cnt;

    hazard_sched #(
        .REG_W(REG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_branch     (id_branch),
        .id_reg_write  (id_reg_write),
        .id_load       (id_load),
        .id_dst        (id_dst),
        .flush         (flush),
        .stall         (stall),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .forward_signal(forward_signal),
        .stall_cause   (stall_cause),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             use_rs;
        logic             use_rt;
        logic             branch;
        logic             reg_write;
        logic             load;
        logic [REG_W-1:0] dst;
        logic             flush;
        logic             e_stall;
        logic [3:0]       e_fwd;
        logic [1:0]       e_cause;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input int valid, input int rs, input int rt, input int urs,
                                input int urt, input int br, input int rw, input int ld,
                                input int dst, input int fl, input int st, input int fwd,
                                input int cause, input int cnt);
        vec_t v;
        v.valid     = 1'(valid);
        v.rs        = REG_W'(rs);
        v.rt        = REG_W'(rt);
        v.use_rs    = 1'(urs);
        v.use_rt    = 1'(urt);
        v.branch    = 1'(br);
        v.reg_write = 1'(rw);
        v.load      = 1'(ld);
        v.dst       = REG_W'(dst);
        v.flush     = 1'(fl);
        v.e_stall   = 1'(st);
        v.e_fwd     = 4'(fwd);
        v.e_cause   = 2'(cause);
        v.e_cnt     = CNT_W'(cnt);
        return v;
    endfunction

    function automatic vec_t nop(input int cnt);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
    endfunction

    task automatic drive(input vec_t v);
        id_valid     = v.valid;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_use_rs    = v.use_rs;
        id_use_rt    = v.use_rt;
        id_branch    = v.branch;
        id_reg_write = v.reg_write;
        id_load      = v.load;
        id_dst       = v.dst;
        flush        = v.flush;
    endtask

    task automatic chk(input string name, input logic e_stall, input logic [3:0] e_fwd,
                       input logic [1:0] e_cause, input logic [CNT_W-1:0] e_cnt);
        n_tests++;
        if (stall !== e_stall) begin
            n_fail++;
            $display("FAIL %s stall got %0b want %0b", name, stall, e_stall);
        end
        n_tests++;
        if (pc_write !== ~e_stall || if_id_write !== ~e_stall) begin
            n_fail++;
            $display("FAIL %s pc_write/if_id_write got %0b/%0b want %0b", name, pc_write,
                     if_id_write, ~e_stall);
        end
        n_tests++;
        if (forward_signal !== e_fwd) begin
            n_fail++;
            $display("FAIL %s forward_signal got %b want %b", name, forward_signal, e_fwd);
        end
        n_tests++;
        if (stall_cause !== e_cause) begin
            n_fail++;
            $display("FAIL %s stall_cause got %b want %b", name, stall_cause, e_cause);
        end
        n_tests++;
        if (stall_cnt !== e_cnt) begin
            n_fail++;
            $display("FAIL %s stall_cnt got %0d want %0d", name, stall_cnt, e_cnt);
        end
    endtask

    vec_t lw5, add5;

    initial begin
        //             v rs rt urs urt br rw ld dst fl | st fwd cause cnt
        vecs[0]  = mk(1, 1, 2, 1, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0);    // add $3
        vecs[1]  = mk(1, 9, 10, 1, 1, 0, 1, 0, 8, 0, 0, 0, 0, 0);   // independent sub $8
        vecs[2]  = nop(0);
        vecs[3]  = nop(0);
        vecs[4]  = mk(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0);    // lw $5
        vecs[5]  = mk(1, 5, 2, 1, 1, 0, 1, 0, 7, 0, 1, 0, 1, 0);    // add rs=$5: load-use
        vecs[6]  = mk(1, 5, 2, 1, 1, 0, 1, 0, 7, 0, 0, 0, 0, 1);    // retry proceeds
        vecs[7]  = nop(1);
        vecs[8]  = nop(1);
        vecs[9]  = nop(1);
        vecs[10] = mk(1, 1, 2, 1, 1, 0, 1, 0, 4, 0, 0, 0, 0, 1);    // add $4
        vecs[11] = mk(1, 4, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 2, 1);    // beq $4,$0: on ALU
        vecs[12] = mk(1, 4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 4, 0, 2);    // forward rs 01
        vecs[13] = nop(2);
        vecs[14] = nop(2);
        vecs[15] = mk(1, 1, 0, 1, 0, 0, 1, 1, 6, 0, 0, 0, 0, 2);    // lw $6
        vecs[16] = mk(1, 7, 6, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 2);    // beq $7,$6: load-use
        vecs[17] = mk(1, 7, 6, 1, 1, 1, 0, 0, 0, 0, 1, 0, 3, 3);    // then branch-on-load
        vecs[18] = mk(1, 7, 6, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0, 4);    // forward rt 10
        vecs[19] = nop(4);
        vecs[20] = nop(4);
        vecs[21] = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4);    // add $0
        vecs[22] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4);    // beq $0,$0
        vecs[23] = mk(1, 1, 0, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 4);    // lw $9
        vecs[24] = mk(1, 9, 0, 1, 0, 0, 1, 0, 11, 1, 0, 0, 0, 4);   // hazard + flush
        vecs[25] = mk(1, 11, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4);   // EX must be a bubble
        vecs[26] = mk(1, 1, 2, 1, 1, 0, 1, 0, 12, 0, 0, 0, 0, 4);   // add $12
        vecs[27] = mk(1, 1, 2, 1, 1, 0, 1, 0, 13, 0, 0, 0, 0, 4);   // sub $13
        vecs[28] = nop(4);
        vecs[29] = mk(1, 13, 12, 1, 1, 1, 0, 0, 0, 0, 0, 6, 0, 4);  // rs MEM 01, rt WB 10
        vecs[30] = mk(1, 12, 13, 1, 1, 1, 0, 0, 0, 0, 0, 2, 0, 4);  // $12 past WB -> 00
        vecs[31] = nop(4);

        lw5  = mk(1, 1, 0, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0);
        add5 = mk(1, 5, 2, 1, 1, 0, 1, 0, 7, 0, 0, 0, 0, 0);

        // Reset state.
        rst = 1'b0;
        drive(nop(0));
        #2;
        chk("reset", 1'b0, 4'b0000, 2'b00, '0);
        #1 rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1 drive(vecs[i]);
            #3 chk($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_fwd, vecs[i].e_cause,
                   vecs[i].e_cnt);
        end

        // Reset asserted in the middle of a load-use stall.
        @(posedge clk);
        #1 drive(lw5);
        #3 chk("mid_lw", 1'b0, 4'b0000, 2'b00, CNT_W'(4));
        @(posedge clk);
        #1 drive(add5);
        #1 chk("mid_stall", 1'b1, 4'b0000, 2'b01, CNT_W'(4));
        #1 rst = 1'b0;
        #1 chk("mid_in_reset", 1'b0, 4'b0000, 2'b00, '0);
        #1 rst = 1'b1;
        #2 chk("mid_post_reset", 1'b0, 4'b0000, 2'b00, '0);

        // Twenty load-use events on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 drive(lw5);
            @(posedge clk);
            #1 drive(add5);
            #3 chk($sformatf("sat%0d", i), 1'b1, 4'b0000, 2'b01,
                   CNT_W'((i > 15) ? 15 : i));
        end
        @(posedge clk);
        #1 drive(nop(0));
        #3 chk("sat_final", 1'b0, 4'b0000, 2'b00, CNT_W'(15));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
